// File: rtl/fixed_point_engine.sv
// Signed Q(WIDTH-FBITS).FBITS arithmetic engine: add/sub, chunked multiply and
// restoring square root behind a start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start
// ADDSUB | single-cycle add or subtract, result written on exit
// MUL    | one chunk product per cycle, then scale and range check
// SQRT   | one root bit per cycle, then result written
// DONE   | result valid for one cycle; a new start is accepted here

module fixed_point_engine #(
    parameter int WIDTH     = 32,
    parameter int FBITS     = 10,
    parameter int MUL_CHUNK = 16,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int N_CHUNK = WIDTH / MUL_CHUNK;
    localparam int N_PROD  = N_CHUNK * N_CHUNK;
    localparam int RAD_W   = ((WIDTH + FBITS + 1) / 2) * 2;
    localparam int ROOT_W  = RAD_W / 2;
    localparam int CNT_MAX = (N_PROD > ROOT_W) ? N_PROD : ROOT_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, SQRT, DONE} state_t;

    state_t               state, state_nxt;
    logic                 sub_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     i_idx, j_idx;
    logic [2*WIDTH-1:0]   acc;
    logic [RAD_W-1:0]     rad_q;
    logic [ROOT_W+1:0]    rem_q;
    logic [ROOT_W-1:0]    root_q;

    logic                 accept;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum_full;
    logic                 as_ovf;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [MUL_CHUNK-1:0] a_chunk, b_chunk;
    logic [2*MUL_CHUNK-1:0] prod;
    logic [2*WIDTH-1:0]   prod_sh, mag_sh, mul_val;
    logic                 mul_fits;
    logic [ROOT_W+1:0]    rem_sh, trial;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == ADDSUB) || (state == MUL) || (state == SQRT);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    case (operation)
                        2'b10:   state_nxt = MUL;
                        2'b11:   state_nxt = SQRT;
                        default: state_nxt = ADDSUB;
                    endcase
                end
            end
            ADDSUB:  state_nxt = DONE;
            MUL:     if (cnt == '0) state_nxt = DONE;
            SQRT:    if (cnt == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sum carries one guard bit so its top bit is the true sign for saturation.
    always_comb begin
        b_eff    = sub_q ? ~b_q : b_q;
        sum_full = {a_q[WIDTH-1], a_q} + {b_eff[WIDTH-1], b_eff} + (WIDTH+1)'(sub_q);
        as_ovf   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        a_mag   = a_q[WIDTH-1] ? -a_q : a_q;
        b_mag   = b_q[WIDTH-1] ? -b_q : b_q;
        a_chunk = '0;
        b_chunk = '0;
        for (int c = 0; c < N_CHUNK; c++) begin
            if (i_idx == IDX_W'(c)) a_chunk = a_mag[c*MUL_CHUNK +: MUL_CHUNK];
            if (j_idx == IDX_W'(c)) b_chunk = b_mag[c*MUL_CHUNK +: MUL_CHUNK];
        end
        prod     = (2*MUL_CHUNK)'(a_chunk) * (2*MUL_CHUNK)'(b_chunk);
        prod_sh  = (2*WIDTH)'(prod) << (MUL_CHUNK * (int'(i_idx) + int'(j_idx)));
        mag_sh   = acc >> FBITS;
        mul_val  = neg_q ? -mag_sh : mag_sh;
        mul_fits = (mul_val[2*WIDTH-1:WIDTH-1] == '0) || (mul_val[2*WIDTH-1:WIDTH-1] == '1);
    end

    always_comb begin
        rem_sh = (rem_q << 2) | (ROOT_W+2)'(rad_q[RAD_W-1 -: 2]);
        trial  = {root_q, 2'b01};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_q    <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            acc      <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                sub_q  <= operation[0];
                a_q    <= operand_1;
                b_q    <= operand_2;
                i_idx  <= '0;
                j_idx  <= '0;
                acc    <= '0;
                rem_q  <= '0;
                root_q <= '0;
                rad_q  <= RAD_W'(operand_1) << FBITS;
                case (operation)
                    2'b10: begin
                        neg_q <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
                        cnt   <= CNT_W'(N_PROD);
                    end
                    2'b11: begin
                        neg_q <= operand_1[WIDTH-1];
                        cnt   <= operand_1[WIDTH-1] ? '0 : CNT_W'(ROOT_W);
                    end
                    default: begin
                        neg_q <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
            case (state)
                ADDSUB: begin
                    overflow <= as_ovf;
                    if (as_ovf && SATURATE != 0)
                        result <= sum_full[WIDTH] ? MAX_NEG : MAX_POS;
                    else
                        result <= sum_full[WIDTH-1:0];
                end
                MUL: begin
                    if (cnt != '0) begin
                        acc <= acc + prod_sh;
                        cnt <= cnt - CNT_W'(1);
                        if (i_idx == IDX_W'(N_CHUNK - 1)) begin
                            i_idx <= '0;
                            j_idx <= j_idx + IDX_W'(1);
                        end else begin
                            i_idx <= i_idx + IDX_W'(1);
                        end
                    end else begin
                        overflow <= !mul_fits;
                        if (!mul_fits && SATURATE != 0)
                            result <= neg_q ? MAX_NEG : MAX_POS;
                        else
                            result <= mul_val[WIDTH-1:0];
                    end
                end
                SQRT: begin
                    if (cnt != '0) begin
                        cnt   <= cnt - CNT_W'(1);
                        rad_q <= rad_q << 2;
                        if (rem_sh >= trial) begin
                            rem_q  <= rem_sh - trial;
                            root_q <= (root_q << 1) | ROOT_W'(1);
                        end else begin
                            rem_q  <= rem_sh;
                            root_q <= root_q << 1;
                        end
                    end else begin
                        overflow <= neg_q;
                        result   <= neg_q ? '0 : WIDTH'(root_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_engine.sv
// Scoreboard bench for fixed_point_engine: saturating and wrapping instances run
// side by side; expectations come from a wide-integer reference model.
`timescale 1ns/1ps
module tb_fixed_point_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  operation = 2'b00;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic [31:0] result, result_w;
    logic        busy, done, overflow;
    logic        busy_w, done_w, overflow_w;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] res_sat;
        logic [31:0] res_wrap;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        scb[$];
    exp_t        mon_e;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    fixed_point_engine #(.WIDTH(32), .FBITS(10), .MUL_CHUNK(16), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .operand_1(operand_1), .operand_2(operand_2),
        .result(result), .busy(busy), .done(done), .overflow(overflow)
    );

    fixed_point_engine #(.WIDTH(32), .FBITS(10), .MUL_CHUNK(16), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .operand_1(operand_1), .operand_2(operand_2),
        .result(result_w), .busy(busy_w), .done(done_w), .overflow(overflow_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r_sat, output logic [31:0] r_wrap,
                                  output logic ovf, output int lat);
        longint sa, sbv, v, x, lo, hi, mid;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        lat = 1;
        v   = 0;
        case (op)
            2'b00: v = sa + sbv;
            2'b01: v = sa - sbv;
            2'b10: begin
                v   = (sa * sbv) / 1024;
                lat = 5;
            end
            default: begin
                if (sa < 0) begin
                    r_sat  = '0;
                    r_wrap = '0;
                    ovf    = 1'b1;
                    return;
                end
                x  = sa * 1024;
                lo = 0;
                hi = 64'd2097152;
                while (lo < hi) begin
                    mid = (lo + hi + 1) / 2;
                    if (mid * mid <= x) lo = mid;
                    else                hi = mid - 1;
                end
                v   = lo;
                lat = 22;
            end
        endcase
        ovf    = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        r_wrap = v[31:0];
        r_sat  = ovf ? ((v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : r_wrap;
    endfunction

    // Caller is at a falling edge; start is held across exactly one rising edge.
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        model(op, a, b, e.res_sat, e.res_wrap, e.ovf, lat);
        e.tag = tag;
        e.cyc = cyc + 1 + lat;
        scb.push_back(e);
        start     = 1'b1;
        operation = op;
        operand_1 = a;
        operand_2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && scb.size() != 0; i++) @(negedge clk);
        #1;
        check_val("drain", scb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (done || done_w) begin
            check_val("done_pair", done_w, done);
            check_val("busy_in_done", busy, 1'b0);
            if (scb.size() == 0) begin
                check_val("unexpected_done", done, 1'b0);
            end else begin
                mon_e = scb.pop_front();
                check_val({mon_e.tag, "_res"}, result, mon_e.res_sat);
                check_val({mon_e.tag, "_ovf"}, overflow, mon_e.ovf);
                check_val({mon_e.tag, "_res_wrap"}, result_w, mon_e.res_wrap);
                check_val({mon_e.tag, "_ovf_wrap"}, overflow_w, mon_e.ovf);
                check_val({mon_e.tag, "_lat"}, cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_result", result, 32'h0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // back-to-back: second add issued in the DONE cycle of the first
        issue("add_1p5_2p25", 2'b00, 32'h0000_0600, 32'h0000_0900);
        @(negedge clk);
        issue("sub_b2b", 2'b01, 32'h0000_0400, 32'h0000_0C00);
        wait_idle();
        issue("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_idle();
        issue("sub_ovf", 2'b01, 32'h8000_0000, 32'h0000_0001);
        wait_idle();
        issue("sub_minb", 2'b01, 32'h0000_0000, 32'h8000_0000);
        wait_idle();

        // start while busy carries different operands and must be ignored
        issue("mul_neg", 2'b10, 32'hFFFF_F600, 32'h0000_1000);
        check_val("mul_busy_c1", busy, 1'b1);
        @(negedge clk);
        check_val("mul_busy_c2", busy, 1'b1);
        start     = 1'b1;
        operation = 2'b00;
        operand_1 = 32'h1234_5678;
        operand_2 = 32'h0000_0400;
        @(negedge clk);
        start = 1'b0;
        check_val("mul_busy_c3", busy, 1'b1);
        wait_idle();

        issue("mul_ovf", 2'b10, 32'h0100_0000, 32'h0100_0000);
        wait_idle();
        issue("mul_min", 2'b10, 32'h8000_0000, 32'h0000_0400);
        wait_idle();
        issue("mul_zero", 2'b10, 32'h0000_0000, 32'hFFFF_F000);
        wait_idle();
        issue("mul_trunc", 2'b10, 32'hFFFF_FFFF, 32'h0000_0003);
        wait_idle();
        issue("sqrt_neg", 2'b11, 32'hFFFF_FC00, 32'h0);
        wait_idle();
        issue("sqrt_zero", 2'b11, 32'h0000_0000, 32'h0);
        wait_idle();
        issue("sqrt_max", 2'b11, 32'h7FFF_FFFF, 32'h0);
        wait_idle();

        for (int k = 0; k < 16; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom >> $urandom_range(0, 24);
            rb  = $urandom >> $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            issue("rand", rop, ra, rb);
            wait_idle();
        end

        issue("sqrt_2", 2'b11, 32'h0000_0800, 32'h0);
        wait_idle();

        // abort a sqrt mid-flight: outputs clear at once, no done follows
        issue("sqrt_abort", 2'b11, 32'h0000_0C00, 32'h0);
        repeat (9) @(negedge clk);
        check_val("abort_busy_pre", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        check_val("abort_result", result, 32'h0);
        check_val("abort_ovf", overflow, 1'b0);
        check_val("abort_result_wrap", result_w, 32'h0);
        scb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue("add_after_rst", 2'b00, 32'h0000_0400, 32'h0000_0400);
        wait_idle();
        repeat (30) @(negedge clk);
        check_val("no_late_done", scb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fixed_point_engine.md
Name: fixed_point_engine

Overview:
- Multi-cycle signed fixed-point arithmetic engine in Q(WIDTH-FBITS).FBITS format.
- Executes add, sub, mul and sqrt under a start/busy/done handshake.
- Multiplier width is parametrised through a reusable MUL_CHUNK x MUL_CHUNK partial-product core; sqrt width is parametrised; overflow is detected, with optional saturation.
- Sits beside the integer ALU in the execute stage; the pipeline stalls while busy=1.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of MUL_CHUNK.
- FBITS, 10, number of fractional bits; 0 < FBITS < WIDTH.
- MUL_CHUNK, 16, width of the partial-product multiplier core.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap (two's-complement truncation).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request; sampled only when busy=0.
- operation  input  2  00 add, 01 sub, 10 mul, 11 sqrt.
- operand_1  input  WIDTH  signed fixed-point operand A (sqrt radicand).
- operand_2  input  WIDTH  signed fixed-point operand B (ignored for sqrt).
- result  output  WIDTH  signed fixed-point result.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: result and overflow are valid.
- overflow  output  1  overflow or domain error for the completed operation.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; result=0, busy=0, done=0, overflow=0; all internal accumulators cleared.
- Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, ADDSUB, MUL, SQRT, DONE.
- Accepting a request:
  - start=1 in IDLE or DONE latches operation, operand_1 and operand_2.
  - The FSM moves to the operation state, and busy=1 from the next cycle.
  - start while busy=1 is ignored; the latched operands are never re-sampled.
- Latency L: start accepted at edge k gives done=1 in the cycle following edge k+L.
  - ADDSUB: L=1.
  - MUL: L=P+1, where P=(WIDTH/MUL_CHUNK)^2. Default L=5.
  - SQRT: L=R/2+1, where R=WIDTH+FBITS rounded up to even. Default R=42, L=22.
  - SQRT with a negative radicand: L=1.
- DONE state lasts one cycle: done=1, busy=0. start in that cycle is accepted (back-to-back issue).
- result and overflow are updated only on entry to DONE and hold until the next DONE or reset.
- Add/sub:
  - Full signed sum computed in WIDTH+1 bits.
  - overflow=1 when the sign bits of the two operands (operand_2 inverted for sub) match and differ from the result sign.
- Mul, per cycle:
  - Operands are converted to magnitudes; the sign is XOR of the operand signs.
  - One chunk pair is multiplied per cycle in order (i,j) = (0,0),(1,0),...,(n-1,n-1).
  - Each product is shifted by (i+j)*MUL_CHUNK and accumulated into a 2*WIDTH-bit accumulator.
- Mul, final cycle:
  - Magnitude is shifted right by FBITS (truncation toward zero), then negated if the sign is 1.
  - overflow=1 if the value does not fit in signed WIDTH.
- Sqrt:
  - Unsigned radicand x = operand_1 << FBITS, R bits wide.
  - Restoring digit-by-digit algorithm, one result bit per cycle.
  - Result = floor(sqrt(x)), zero-extended to WIDTH; never overflows.
  - Negative radicand: result=0, overflow=1.
- On overflow:
  - SATURATE=1: result = 0x7FF..F if positive, 0x800..0 if negative.
  - SATURATE=0: low WIDTH bits are kept.
  - overflow=1 in both modes.
- Special operand values:
  - Zero operands need no special path: mul gives 0, sqrt(0) gives 0, both with normal latency.
  - The most-negative operand in mul uses magnitude 2^(WIDTH-1) without error.

Test Plan:
- Add 0x00000600 + 0x00000900 (1.5 + 2.25) -> done 1 cycle after start, result=0x00000F00, overflow=0.
- Add 0x7FFFFFFF + 0x00000001, SATURATE=1 -> result=0x7FFFFFFF, overflow=1. Same with SATURATE=0 -> result=0x80000000, overflow=1.
- Mul 0xFFFFF600 * 0x00001000 (-2.5 * 4.0) -> done at L=5, result=0xFFFFD800, overflow=0. busy=1 for cycles 1-4; a start pulse at cycle 2 is ignored.
- Mul 0x01000000 * 0x01000000 (16384.0^2) -> result=0x7FFFFFFF, overflow=1. Mul 0x80000000 * 0x00000400 (x1.0) -> result=0x80000000, overflow=0.
- Sqrt 0x00000800 (2.0) -> done at L=22, result=0x000005A8, overflow=0. Sqrt 0xFFFFFC00 (-1.0) -> done at L=1, result=0, overflow=1.
- Start sqrt, assert reset=0 at cycle 10 -> busy, done, result and overflow go to 0 immediately. After release, add 1+1 (0x400 + 0x400) completes normally with result=0x800.
